sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 73 +++++++
 rtl/sdram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
// ----------------
// Bundles every non-clock, non-reset signal of the SDRAM command arbiter.
//
// Engine side (driven by the master, consumed by the arbiter):
//   init_end, init_cmd/init_ba/init_addr          init engine status and command bus
//   aref_req, aref_end, aref_cmd/aref_ba/aref_addr refresh engine request, done, command bus
//   wr_req, wr_end, wr_cmd/wr_ba/wr_addr          write engine request, done, command bus
//   wr_sdram_en, wr_sdram_data                    write engine data-valid and data
//   rd_req, rd_end, rd_cmd/rd_ba/rd_addr          read engine request, done, command bus
// Arbiter side (driven by the arbiter, consumed by the master):
//   aref_en, wr_en, rd_en                         one-hot grants
//   sdram_cmd/sdram_ba/sdram_addr                 muxed SDRAM command bus
//   sdram_dq_out, sdram_dq_oe                     write data and pad output enable
//   timeout_err                                   sticky grant-timeout flag
interface sdram_arbiter_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;

  logic        aref_req;
  logic        aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_ba;
  logic [12:0] aref_addr;

  logic        wr_req;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;

  logic        aref_en;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        timeout_err;

  // Engines / environment side
  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe,
    input  timeout_err
  );

  // Arbiter side
  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe,
    output timeout_err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// -------------
// Shares one SDRAM command bus between the init, auto-refresh, write and
// read engines. After the init engine reports completion the arbiter grants
// the bus to one engine at a time: refresh has absolute priority, and write
// and read alternate when both are pending. A grant lasts until the owning
// engine pulses its *_end or the grant has been held GRANT_TIMEOUT cycles,
// in which case the grant is pulled back and timeout_err latches until reset.
// Between any two grants there is always at least one idle (NOP) cycle.
//
// Ports:
//   wr_clk    in  clock, rising edge
//   wr_rst_n  in  asynchronous active-low reset
//   bus       sdram_arbiter_if.slave (engine buses in, grants and SDRAM bus out)
//
// Grants, the command mux and the pad enable are decoded from the state
// register alone (plus the write engine's data-valid for the pad), so an
// asynchronous reset removes a grant and its command in the same cycle.
module sdram_arbiter #(
  parameter int GRANT_TIMEOUT = 1023
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  sdram_arbiter_if.slave   bus
);

  // Counter is at least 10 bits, wider if the timeout needs it.
  localparam int CNT_W_MIN = $clog2(GRANT_TIMEOUT + 1);
  localparam int CNT_W     = (CNT_W_MIN > 10) ? CNT_W_MIN : 10;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

  // Idle bus value: {CS#,RAS#,CAS#,WE#} = NOP, all-ones bank/address.
  localparam logic [3:0]  NOP_CMD_C  = 4'b0111;
  localparam logic [1:0]  NOP_BA_C   = 2'b11;
  localparam logic [12:0] NOP_ADDR_C = 13'h1fff;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           arb_pick_s;
  logic             last_wr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             timeout_err_r;
  logic             grant_end_s;
  logic             cnt_hit_s;

  logic [3:0]       cmd_s;
  logic [1:0]       ba_s;
  logic [12:0]      addr_s;
  logic             dq_oe_s;
  logic [15:0]      dq_out_s;

  // Next grant chosen while idle: refresh first, then write/read fairness.
  always_comb begin
    arb_pick_s = ST_ARBIT;
    if (bus.aref_req) begin
      arb_pick_s = ST_AREF;
    end else if (bus.wr_req && bus.rd_req) begin
      // Both pending: serve whichever did not go last.
      arb_pick_s = last_wr_r ? ST_READ : ST_WRITE;
    end else if (bus.wr_req) begin
      arb_pick_s = ST_WRITE;
    end else if (bus.rd_req) begin
      arb_pick_s = ST_READ;
    end else begin
      arb_pick_s = ST_ARBIT;
    end
  end

  // Done pulse of the engine that currently owns the bus; others are ignored.
  always_comb begin
    grant_end_s = 1'b0;
    case (state_r)
      ST_AREF:  grant_end_s = bus.aref_end;
      ST_WRITE: grant_end_s = bus.wr_end;
      ST_READ:  grant_end_s = bus.rd_end;
      default:  grant_end_s = 1'b0;
    endcase
  end

  // The grant expires on the edge where the count would reach the limit,
  // giving exactly GRANT_TIMEOUT grant cycles. Being already at the limit
  // (only possible with GRANT_TIMEOUT of zero) also counts as expired.
  assign cnt_hit_s = ((cnt_r + ONE_C) == TIMEOUT_C) || (cnt_r == TIMEOUT_C);

  // Arbiter state machine, fairness flag, grant counter and timeout flag.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_r       <= ST_INIT;
      last_wr_r     <= 1'b0;
      cnt_r         <= ZERO_C;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= ZERO_C;
          if (bus.init_end) begin
            state_r <= ST_ARBIT;
          end else begin
            state_r <= ST_INIT;
          end
        end

        ST_ARBIT: begin
          cnt_r   <= ZERO_C;
          state_r <= arb_pick_s;
          if (arb_pick_s == ST_WRITE) begin
            last_wr_r <= 1'b1;
          end else if (arb_pick_s == ST_READ) begin
            last_wr_r <= 1'b0;
          end else begin
            last_wr_r <= last_wr_r;
          end
        end

        ST_AREF, ST_WRITE, ST_READ: begin
          // Saturating count of cycles this grant has been held.
          if (cnt_r != TIMEOUT_C) begin
            cnt_r <= cnt_r + ONE_C;
          end else begin
            cnt_r <= cnt_r;
          end
          if (cnt_hit_s) begin
            timeout_err_r <= 1'b1;
          end else begin
            timeout_err_r <= timeout_err_r;
          end
          // Grants always fall back to idle, never straight to another grant.
          if (grant_end_s || cnt_hit_s) begin
            state_r <= ST_ARBIT;
          end else begin
            state_r <= state_r;
          end
        end

        default: begin
          state_r <= ST_INIT;
          cnt_r   <= ZERO_C;
        end
      endcase
    end
  end

  // Command bus mux: the owner of the bus drives it, idle drives a NOP.
  always_comb begin
    cmd_s  = bus.init_cmd;
    ba_s   = bus.init_ba;
    addr_s = bus.init_addr;
    case (state_r)
      ST_INIT: begin
        cmd_s  = bus.init_cmd;
        ba_s   = bus.init_ba;
        addr_s = bus.init_addr;
      end
      ST_ARBIT: begin
        cmd_s  = NOP_CMD_C;
        ba_s   = NOP_BA_C;
        addr_s = NOP_ADDR_C;
      end
      ST_AREF: begin
        cmd_s  = bus.aref_cmd;
        ba_s   = bus.aref_ba;
        addr_s = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_s  = bus.wr_cmd;
        ba_s   = bus.wr_ba;
        addr_s = bus.wr_addr;
      end
      ST_READ: begin
        cmd_s  = bus.rd_cmd;
        ba_s   = bus.rd_ba;
        addr_s = bus.rd_addr;
      end
      default: begin
        cmd_s  = NOP_CMD_C;
        ba_s   = NOP_BA_C;
        addr_s = NOP_ADDR_C;
      end
    endcase
  end

  // Write data reaches the pad only while the write engine owns the bus.
  always_comb begin
    dq_oe_s  = 1'b0;
    dq_out_s = 16'h0000;
    if ((state_r == ST_WRITE) && bus.wr_sdram_en) begin
      dq_oe_s  = 1'b1;
      dq_out_s = bus.wr_sdram_data;
    end else begin
      dq_oe_s  = 1'b0;
      dq_out_s = 16'h0000;
    end
  end

  assign bus.aref_en      = (state_r == ST_AREF);
  assign bus.wr_en        = (state_r == ST_WRITE);
  assign bus.rd_en        = (state_r == ST_READ);
  assign bus.sdram_cmd    = cmd_s;
  assign bus.sdram_ba     = ba_s;
  assign bus.sdram_addr   = addr_s;
  assign bus.sdram_dq_oe  = dq_oe_s;
  assign bus.sdram_dq_out = dq_out_s;
  assign bus.timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter (GRANT_TIMEOUT = 8).
// Directed scenarios check the documented behaviours with fixed expectations;
// a randomized run is checked against an ownership-based reference model.
module tb_sdram_arbiter;
  localparam int GT = 8;

  logic wr_clk;
  logic wr_rst_n;
  int   n_checks;
  int   n_fail;

  // Reference model: who owns the bus and for how long.
  bit   m_ready;      // init finished
  int   m_owner;      // -1 none, 0 refresh, 1 write, 2 read
  int   m_held;       // cycles the current owner has held the bus
  bit   m_last_wr;    // last write/read grant went to write
  bit   m_err;

  logic [2:0]  e_grant;
  logic [18:0] e_bus;
  logic [16:0] e_dq;

  sdram_arbiter_if bus ();

  sdram_arbiter #(.GRANT_TIMEOUT(GT)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .bus      (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.init_end = 1'b0; bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_sdram_en = 1'b0;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;
  endtask

  task automatic rand_buses();
    bus.init_cmd = 4'($urandom); bus.init_ba = 2'($urandom); bus.init_addr = 13'($urandom);
    bus.aref_cmd = 4'($urandom); bus.aref_ba = 2'($urandom); bus.aref_addr = 13'($urandom);
    bus.wr_cmd = 4'($urandom); bus.wr_ba = 2'($urandom); bus.wr_addr = 13'($urandom);
    bus.rd_cmd = 4'($urandom); bus.rd_ba = 2'($urandom); bus.rd_addr = 13'($urandom);
    bus.wr_sdram_data = 16'($urandom);
  endtask

  task automatic model_reset();
    m_ready = 1'b0; m_owner = -1; m_held = 0; m_last_wr = 1'b0; m_err = 1'b0;
  endtask

  task automatic apply_reset();
    tick();
    wr_rst_n = 1'b0;
    #2;
    wr_rst_n = 1'b1;
    model_reset();
  endtask

  // Reset, then leave init so the arbiter sits idle.
  task automatic go_idle();
    clear_inputs();
    apply_reset();
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;
  endtask

  // Expected outputs for the model's current owner and the present inputs.
  task automatic model_expect();
    if (!m_ready) begin
      e_grant = 3'b000;
      e_bus   = {bus.init_cmd, bus.init_ba, bus.init_addr};
    end else if (m_owner == 0) begin
      e_grant = 3'b100;
      e_bus   = {bus.aref_cmd, bus.aref_ba, bus.aref_addr};
    end else if (m_owner == 1) begin
      e_grant = 3'b010;
      e_bus   = {bus.wr_cmd, bus.wr_ba, bus.wr_addr};
    end else if (m_owner == 2) begin
      e_grant = 3'b001;
      e_bus   = {bus.rd_cmd, bus.rd_ba, bus.rd_addr};
    end else begin
      e_grant = 3'b000;
      e_bus   = {4'b0111, 2'b11, 13'h1fff};
    end
    if (m_ready && m_owner == 1 && bus.wr_sdram_en) e_dq = {1'b1, bus.wr_sdram_data};
    else e_dq = {1'b0, 16'h0000};
  endtask

  // Advance the model across one rising clock edge.
  task automatic model_advance();
    bit done;
    if (!m_ready) begin
      if (bus.init_end) m_ready = 1'b1;
    end else if (m_owner < 0) begin
      if (bus.aref_req) m_owner = 0;
      else if (bus.wr_req && bus.rd_req) m_owner = m_last_wr ? 2 : 1;
      else if (bus.wr_req) m_owner = 1;
      else if (bus.rd_req) m_owner = 2;
      if (m_owner == 1) m_last_wr = 1'b1;
      if (m_owner == 2) m_last_wr = 1'b0;
      m_held = 0;
    end else begin
      m_held = m_held + 1;
      done = (m_owner == 0 && bus.aref_end) || (m_owner == 1 && bus.wr_end) ||
             (m_owner == 2 && bus.rd_end);
      if (m_held >= GT) m_err = 1'b1;
      if (done || m_held >= GT) m_owner = -1;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.init_end = 1'b1; bus.wr_req = 1'b1; bus.wr_sdram_en = 1'b1;
    wr_rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_buses();
      tick();
      n_checks++;
      if ({bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.timeout_err} !== 5'b00000) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b expected 00000",
                 {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.timeout_err});
      end
      n_checks++;
      if ({bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr} !== {bus.init_cmd, bus.init_ba, bus.init_addr}) begin
        n_fail++;
        $display("FAIL reset_cmd_mux: got %h expected %h",
                 {bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr}, {bus.init_cmd, bus.init_ba, bus.init_addr});
      end
    end
    wr_rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_init_hold();
    clear_inputs();
    apply_reset();
    bus.wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_buses();
      tick();
      n_checks++;
      if (bus.wr_en !== 1'b0 || bus.sdram_cmd !== bus.init_cmd) begin
        n_fail++;
        $display("FAIL init_hold cycle %0d: wr_en=%b cmd=%h expected wr_en=0 cmd=%h",
                 i, bus.wr_en, bus.sdram_cmd, bus.init_cmd);
      end
    end
    bus.init_end = 1'b1;
    tick();
    bus.init_end = 1'b0;  // dropping init_end after exit must not matter
    n_checks++;
    if ({bus.wr_en, bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr} !== {1'b0, 4'b0111, 2'b11, 13'h1fff}) begin
      n_fail++;
      $display("FAIL init_exit_nop: got %h expected %h",
               {bus.wr_en, bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr}, {1'b0, 4'b0111, 2'b11, 13'h1fff});
    end
    tick();
    n_checks++;
    if (bus.wr_en !== 1'b1 || bus.sdram_cmd !== bus.wr_cmd) begin
      n_fail++;
      $display("FAIL init_then_write: wr_en=%b cmd=%h expected 1 %h", bus.wr_en, bus.sdram_cmd, bus.wr_cmd);
    end
    bus.wr_end = 1'b1; bus.wr_req = 1'b0;
    tick();
    clear_inputs();
  endtask

  task automatic test_priority();
    go_idle();
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    bus.aref_req = 1'b0;
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b100 || bus.sdram_cmd !== bus.aref_cmd) begin
      n_fail++;
      $display("FAIL prio_aref_first: grants=%b cmd=%h expected 100 %h",
               {bus.aref_en, bus.wr_en, bus.rd_en}, bus.sdram_cmd, bus.aref_cmd);
    end
    bus.aref_end = 1'b1;
    tick();
    bus.aref_end = 1'b0;
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr} !==
        {3'b000, 4'b0111, 2'b11, 13'h1fff}) begin
      n_fail++;
      $display("FAIL prio_nop_after_aref: got %h expected %h",
               {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr},
               {3'b000, 4'b0111, 2'b11, 13'h1fff});
    end
    tick();
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_write_second: grants=%b expected 010", {bus.aref_en, bus.wr_en, bus.rd_en});
    end
    bus.wr_end = 1'b1; bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd} !== {3'b000, 4'b0111}) begin
      n_fail++;
      $display("FAIL prio_nop_after_write: got %h expected %h",
               {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd}, {3'b000, 4'b0111});
    end
    tick();
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b001) begin
      n_fail++;
      $display("FAIL prio_read_third: grants=%b expected 001", {bus.aref_en, bus.wr_en, bus.rd_en});
    end
    bus.rd_end = 1'b1; bus.rd_req = 1'b0;
    tick();
    clear_inputs();
  endtask

  task automatic test_alternate();
    logic [2:0] want;
    go_idle();
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      want = (g % 2 == 0) ? 3'b010 : 3'b001;
      n_checks++;
      if ({bus.aref_en, bus.wr_en, bus.rd_en} !== want) begin
        n_fail++;
        $display("FAIL alternate_grant %0d: grants=%b expected %b", g, {bus.aref_en, bus.wr_en, bus.rd_en}, want);
      end
      if (g % 2 == 0) bus.wr_end = 1'b1; else bus.rd_end = 1'b1;
      tick();
      bus.wr_end = 1'b0; bus.rd_end = 1'b0;
      n_checks++;
      if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b000) begin
        n_fail++;
        $display("FAIL alternate_gap %0d: grants=%b expected 000", g, {bus.aref_en, bus.wr_en, bus.rd_en});
      end
    end
    clear_inputs();
  endtask

  task automatic test_dq_and_ignore();
    go_idle();
    bus.wr_req = 1'b1; bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'hA5A5;
    tick();
    n_checks++;
    if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== {1'b1, 16'hA5A5}) begin
      n_fail++;
      $display("FAIL dq_write: got %h expected %h", {bus.sdram_dq_oe, bus.sdram_dq_out}, {1'b1, 16'hA5A5});
    end
    bus.wr_sdram_en = 1'b0;
    #1;
    n_checks++;
    if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== 17'h0) begin
      n_fail++;
      $display("FAIL dq_write_noen: got %h expected 0", {bus.sdram_dq_oe, bus.sdram_dq_out});
    end
    bus.wr_end = 1'b1; bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.wr_sdram_en = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    tick();
    bus.rd_req = 1'b0;
    n_checks++;
    if ({bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL dq_read: got %h expected %h", {bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out},
               {1'b1, 1'b0, 16'h0000});
    end
    // Foreign done pulses and a fresh refresh request must not end the read.
    bus.wr_end = 1'b1; bus.aref_end = 1'b1;
    tick();
    bus.wr_end = 1'b0; bus.aref_end = 1'b0; bus.aref_req = 1'b1;
    tick();
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b001) begin
      n_fail++;
      $display("FAIL ignore_foreign: grants=%b expected 001", {bus.aref_en, bus.wr_en, bus.rd_en});
    end
    bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    tick();
    n_checks++;
    if ({bus.aref_en, bus.wr_en, bus.rd_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL aref_deferred: grants=%b expected 100", {bus.aref_en, bus.wr_en, bus.rd_en});
    end
    bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout();
    go_idle();
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    for (int c = 1; c < GT; c++) begin
      tick();
      n_checks++;
      if (bus.rd_en !== 1'b1 || bus.timeout_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold %0d: rd_en=%b err=%b expected 1 0", c, bus.rd_en, bus.timeout_err);
      end
    end
    tick();
    n_checks++;
    if ({bus.rd_en, bus.sdram_cmd, bus.timeout_err} !== {1'b0, 4'b0111, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_release: got %h expected %h", {bus.rd_en, bus.sdram_cmd, bus.timeout_err},
               {1'b0, 4'b0111, 1'b1});
    end
    bus.wr_req = 1'b1;
    tick();
    bus.wr_end = 1'b1; bus.wr_req = 1'b0;
    tick();
    bus.wr_end = 1'b0;
    tick();
    n_checks++;
    if (bus.timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b expected 1", bus.timeout_err);
    end
    apply_reset();
    #1;
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b expected 0", bus.timeout_err);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_grant();
    go_idle();
    bus.wr_req = 1'b1; bus.wr_sdram_en = 1'b1;
    tick();
    n_checks++;
    if ({bus.wr_en, bus.sdram_dq_oe} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: got %b expected 11", {bus.wr_en, bus.sdram_dq_oe});
    end
    #1;
    wr_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.wr_en, bus.sdram_dq_oe, bus.sdram_cmd} !== {2'b00, bus.init_cmd}) begin
      n_fail++;
      $display("FAIL midrst_drop: got %h expected %h", {bus.wr_en, bus.sdram_dq_oe, bus.sdram_cmd},
               {2'b00, bus.init_cmd});
    end
    tick();
    wr_rst_n = 1'b1;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_random();
    clear_inputs();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      rand_buses();
      bus.init_end    = 1'($urandom_range(0, 1));
      bus.aref_req    = ($urandom_range(0, 7) == 0);
      bus.aref_end    = ($urandom_range(0, 3) == 0);
      bus.wr_req      = 1'($urandom_range(0, 1));
      bus.wr_end      = ($urandom_range(0, 3) == 0);
      bus.rd_req      = 1'($urandom_range(0, 1));
      bus.rd_end      = ($urandom_range(0, 4) == 0);
      bus.wr_sdram_en = 1'($urandom_range(0, 1));
      #1;
      model_expect();
      n_checks++;
      if ({bus.aref_en, bus.wr_en, bus.rd_en} !== e_grant) begin
        n_fail++;
        $display("FAIL rand_grant @%0d: got %b expected %b", i, {bus.aref_en, bus.wr_en, bus.rd_en}, e_grant);
      end
      n_checks++;
      if ({bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr} !== e_bus) begin
        n_fail++;
        $display("FAIL rand_cmd @%0d: got %h expected %h", i, {bus.sdram_cmd, bus.sdram_ba, bus.sdram_addr}, e_bus);
      end
      n_checks++;
      if ({bus.sdram_dq_oe, bus.sdram_dq_out} !== e_dq) begin
        n_fail++;
        $display("FAIL rand_dq @%0d: got %h expected %h", i, {bus.sdram_dq_oe, bus.sdram_dq_out}, e_dq);
      end
      n_checks++;
      if (bus.timeout_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_err @%0d: got %b expected %b", i, bus.timeout_err, m_err);
      end
      model_advance();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    wr_rst_n = 1'b0;
    clear_inputs();
    rand_buses();
    model_reset();
    test_reset();
    test_init_hold();
    test_priority();
    test_alternate();
    test_dq_and_ignore();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
